// File: rtl/i2s_pkg.sv
// Shared I2S definitions for the receiver and the transmitter.
//   rx_state_e : receiver lock state (Unlocked / Left / Right)
//   LRCK_LEFT / LRCK_RIGHT : word-select polarity on the LRCK line
package i2s_pkg;

  typedef enum logic [1:0] {
    RX_UNLOCKED = 2'd0,
    RX_LEFT     = 2'd1,
    RX_RIGHT    = 2'd2
  } rx_state_e;

  localparam logic LRCK_LEFT  = 1'b0;
  localparam logic LRCK_RIGHT = 1'b1;

endpackage

// File: rtl/i2s_sync.sv
// Multi-flop synchroniser for one asynchronous I2S line.
//   clk_i, rstn_i : system clock, async active-low reset
//   d_i           : asynchronous input
//   q_o           : synchronised value (last sync stage)
//   prev_o        : q_o delayed by one clk_i cycle
//   rise_o        : q_o high while prev_o low (one-cycle rise pulse)
module i2s_sync #(
  parameter int SyncStages = 2
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic d_i,
  output logic q_o,
  output logic prev_o,
  output logic rise_o
);

  logic [SyncStages-1:0] sync_d, sync_q;
  logic                  prev_d, prev_q;

  // Next values: shift the input through the chain, remember the last stage.
  always_comb begin
    sync_d = {sync_q[SyncStages-2:0], d_i};
    prev_d = sync_q[SyncStages-1];
  end

  // Synchroniser chain and previous-value register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign q_o    = sync_q[SyncStages-1];
  assign prev_o = prev_q;
  assign rise_o = sync_q[SyncStages-1] & ~prev_q;

endmodule

// File: rtl/i2s_rx_slave.sv
// I2S slave receiver: oversamples SCLK/LRCK/SDAT, locks to frame boundaries,
// deserialises MSB-first words and presents left/right pairs on valid/ready.
//   clk_i, rstn_i              : system clock (>= 8x SCLK), async active-low reset
//   rx_en_i                    : receiver enable, low forces Unlocked
//   i2s_sclk_i/lrck_i/sdat_i   : external I2S lines (asynchronous)
//   rx_ldata_o, rx_rdata_o     : received pair
//   rx_valid_o, rx_ready_i     : pair handshake
//   overrun_o                  : pulse, unaccepted pair overwritten
//   frame_err_o                : pulse, short word detected
module i2s_rx_slave
  import i2s_pkg::*;
#(
  parameter int DataWidth  = 24,
  parameter int SyncStages = 2
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 rx_en_i,
  input  logic                 i2s_sclk_i,
  input  logic                 i2s_lrck_i,
  input  logic                 i2s_sdat_i,
  output logic [DataWidth-1:0] rx_ldata_o,
  output logic [DataWidth-1:0] rx_rdata_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic                 overrun_o,
  output logic                 frame_err_o
);

  localparam int CntW = $clog2(DataWidth + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(DataWidth);
  localparam logic [CntW-1:0] CntLast = CntW'(DataWidth - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  logic sclk_s, sclk_rise_s, lrck_s, sdat_s;
  logic sclk_prev_unused, lrck_prev_unused, lrck_rise_unused;
  logic sdat_prev_unused, sdat_rise_unused;

  i2s_sync #(.SyncStages(SyncStages)) u_sync_sclk (
    .clk_i(clk_i), .rstn_i(rstn_i), .d_i(i2s_sclk_i),
    .q_o(sclk_s), .prev_o(sclk_prev_unused), .rise_o(sclk_rise_s)
  );
  i2s_sync #(.SyncStages(SyncStages)) u_sync_lrck (
    .clk_i(clk_i), .rstn_i(rstn_i), .d_i(i2s_lrck_i),
    .q_o(lrck_s), .prev_o(lrck_prev_unused), .rise_o(lrck_rise_unused)
  );
  i2s_sync #(.SyncStages(SyncStages)) u_sync_sdat (
    .clk_i(clk_i), .rstn_i(rstn_i), .d_i(i2s_sdat_i),
    .q_o(sdat_s), .prev_o(sdat_prev_unused), .rise_o(sdat_rise_unused)
  );

  rx_state_e              state_d, state_q;
  logic [CntW-1:0]        cnt_d, cnt_q;
  logic [DataWidth-1:0]   shift_d, shift_q;
  logic [DataWidth-1:0]   left_d, left_q;
  logic [DataWidth-1:0]   ldata_d, ldata_q;
  logic [DataWidth-1:0]   rdata_d, rdata_q;
  logic                   lrck_last_d, lrck_last_q;
  logic                   valid_d, valid_q;
  logic                   overrun_d, overrun_q;
  logic                   ferr_d, ferr_q;

  logic                   chan_edge_s, fall_edge_s, rise_edge_s, pair_s;
  logic [DataWidth-1:0]   shift_in_s;

  // Channel edges compare LRCK at this SCLK rise with LRCK at the previous one.
  assign chan_edge_s = sclk_rise_s & (lrck_s != lrck_last_q);
  assign fall_edge_s = chan_edge_s & (lrck_s == LRCK_LEFT);
  assign rise_edge_s = chan_edge_s & (lrck_s == LRCK_RIGHT);
  assign shift_in_s  = {shift_q[DataWidth-2:0], sdat_s};

  // Next-state, deserialiser and output handshake logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    left_d      = left_q;
    ldata_d     = ldata_q;
    rdata_d     = rdata_q;
    valid_d     = valid_q;
    overrun_d   = 1'b0;
    ferr_d      = 1'b0;
    pair_s      = 1'b0;

    if (sclk_rise_s) begin
      lrck_last_d = lrck_s;
    end else begin
      lrck_last_d = lrck_last_q;
    end

    // Delay slot clears the counter; otherwise shift until the word is full.
    if (!rx_en_i || chan_edge_s) begin
      cnt_d = '0;
    end else if (sclk_rise_s && (cnt_q < CntFull)) begin
      shift_d = shift_in_s;
      cnt_d   = cnt_q + CntOne;
    end else begin
      cnt_d = cnt_q;
    end

    if (!rx_en_i) begin
      state_d = RX_UNLOCKED;
    end else begin
      case (state_q)
        RX_UNLOCKED: begin
          if (fall_edge_s) begin
            state_d = RX_LEFT;
          end else begin
            state_d = RX_UNLOCKED;
          end
        end
        RX_LEFT: begin
          if (rise_edge_s && (cnt_q == CntFull)) begin
            state_d = RX_RIGHT;
            left_d  = shift_q;
          end else if (rise_edge_s) begin
            state_d = RX_UNLOCKED;
            ferr_d  = 1'b1;
          end else begin
            state_d = RX_LEFT;
          end
        end
        RX_RIGHT: begin
          if (fall_edge_s && (cnt_q == CntFull)) begin
            state_d = RX_LEFT;
          end else if (fall_edge_s) begin
            state_d = RX_UNLOCKED;
            ferr_d  = 1'b1;
          end else if (sclk_rise_s && !chan_edge_s && (cnt_q == CntLast)) begin
            // Last right bit arrives now: the pair is complete this cycle.
            pair_s = 1'b1;
          end else begin
            state_d = RX_RIGHT;
          end
        end
        default: begin
          state_d = RX_UNLOCKED;
        end
      endcase
    end

    // A new pair always wins; overrun only if the old one was not taken now.
    if (pair_s) begin
      ldata_d   = left_q;
      rdata_d   = shift_in_s;
      valid_d   = 1'b1;
      overrun_d = valid_q & ~rx_ready_i;
    end else if (valid_q && rx_ready_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= RX_UNLOCKED;
      cnt_q       <= '0;
      shift_q     <= '0;
      left_q      <= '0;
      ldata_q     <= '0;
      rdata_q     <= '0;
      lrck_last_q <= 1'b0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      left_q      <= left_d;
      ldata_q     <= ldata_d;
      rdata_q     <= rdata_d;
      lrck_last_q <= lrck_last_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      ferr_q      <= ferr_d;
    end
  end

  assign rx_ldata_o  = ldata_q;
  assign rx_rdata_o  = rdata_q;
  assign rx_valid_o  = valid_q;
  assign overrun_o   = overrun_q;
  assign frame_err_o = ferr_q;

endmodule

// File: doc/i2s_rx_slave.md
Name: i2s_rx_slave

Overview:
- I2S receiver for an external master such as an ADC or codec that drives SCLK, LRCK and SDAT.
- Oversamples all three lines in the clk_i domain, locks to frame boundaries and deserialises MSB-first words.
- Delivers left/right sample pairs on a valid/ready interface.
- Counterpart of i2s_tx_master; the I2S framing is the same, so a frame produced by i2s_tx_master is received unchanged.

Parameters:
- DataWidth, 24, bits per channel word captured (MSB-first); extra slot bits are ignored.
- SyncStages, 2, synchroniser depth on each I2S input; must be >= 2.

Ports:
- clk_i  in  1  system clock; must be >= 8x SCLK frequency.
- rstn_i  in  1  reset, asynchronous, active-low.
- rx_en_i  in  1  receiver enable; low forces Unlocked.
- i2s_sclk_i  in  1  external bit clock (asynchronous).
- i2s_lrck_i  in  1  external word select; 0 = left, 1 = right.
- i2s_sdat_i  in  1  external serial data.
- rx_ldata_o  out  DataWidth  left sample, raw two's complement.
- rx_rdata_o  out  DataWidth  right sample, raw two's complement.
- rx_valid_o  out  1  pair available.
- rx_ready_i  in  1  consumer accepts pair.
- overrun_o  out  1  one-cycle pulse: an unaccepted pair was overwritten.
- frame_err_o  out  1  one-cycle pulse: short word detected.

Behaviour:
- Reset: every output is 0; state Unlocked; bit counter 0; shift register 0; synchronisers 0.
- Input sampling: SCLK, LRCK and SDAT each pass through SyncStages flops. An SCLK rise is detected when the last sync stage is 1 and the previous value is 0. Only SCLK rises act; LRCK and SDAT are taken from the same sync stage at that cycle.
- Edge definitions: a "channel edge" is an SCLK rise at which sampled LRCK differs from the LRCK sampled at the previous SCLK rise. Falling channel edge = LRCK 1->0; rising channel edge = LRCK 0->1.
- I2S delay: the SCLK rise that detects a channel edge is the delay slot. Its bit is discarded and the bit counter clears to 0. The next DataWidth rises shift SDAT into the shift register, MSB first. The counter saturates at DataWidth; later bits in the slot are ignored.
- Unlocked -> Left: on a falling channel edge while rx_en_i = 1.
- Left -> Right: on a rising channel edge when count == DataWidth; left word latched internally.
- Left -> Unlocked: on a rising channel edge when count < DataWidth; frame_err_o pulses.
- Right, DataWidth-th bit captured: rx_rdata_o and rx_ldata_o load, and rx_valid_o = 1, at the same clk_i edge as the shift. Latency is SyncStages+1 clk_i edges after the first sync flop samples that SCLK rise.
- Right -> Left: on a falling channel edge when count == DataWidth. This is a continuous stream; the edge is that frame's delay slot.
- Right -> Unlocked: on a falling channel edge when count < DataWidth; frame_err_o pulses and no pair is produced.
- rx_en_i = 0: next state Unlocked and counter cleared. A pending rx_valid_o stays asserted until accepted.
- Handshake:
  - rx_valid_o holds, with data stable, until rx_valid_o & rx_ready_i.
  - Acceptance with no new pair: rx_valid_o drops at the next edge.
  - New pair while valid and not accepted that cycle: the new pair overwrites, valid stays 1, overrun_o pulses.
  - New pair in the same cycle as acceptance: the new pair loads, valid stays 1, no overrun.
- Bit counter width: $clog2(DataWidth+1). There is no sign extension.
- Reset asserted mid-word: immediate return to reset values. After release, nothing is output until a new falling channel edge occurs and a full frame follows.

Decomposition:
- Shared package i2s_pkg holds the rx state encodings (Unlocked = 0, Left = 1, Right = 2) and the Left = 0 / Right = 1 LRCK polarity constant, for reuse by i2s_tx_master.
- One sub-module, i2s_sync: SyncStages-deep synchroniser plus registered previous value, with a rise-pulse output. It is instantiated three times; only the SCLK instance uses the rise pulse.

Test Plan:
- Reset: hold rstn_i low for 5 cycles with random I2S activity -> all outputs 0, and rx_valid_o stays 0 until a full frame is received after release.
- Single frame: clk_i = 16x SCLK, 64 SCLK per frame, L = 24'hFC3C0F, R = 24'h333333, rx_ready_i = 1 -> one pair matches, with rx_valid_o high exactly 1 cycle starting SyncStages+1 edges after the 24th right bit rise.
- Lock: assert rx_en_i mid-right channel -> the partial frame is discarded; the first pair is the next full frame (L = 24'h555555, R = 24'hAAAAAA).
- Backpressure: rx_ready_i = 0 across two frames (A then B) -> overrun_o pulses exactly once, outputs show B, and rx_valid_o drops one cycle after rx_ready_i = 1.
- Short word: 16 SCLK per channel with DataWidth = 24 -> frame_err_o pulses at the left->right channel edge and no valid is produced. A following 64-SCLK frame is received correctly.
- Loopback: i2s_tx_master(2, 512, 64, 24) drives the inputs with 100 random pairs -> every received pair equals the transmitted pair, in order, with no errors.
